mux8_rr_arbiter: RTL and testbench
==================================

// Module: mux8_rr_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer that shares one 8:1 selection datapath among
//   8 requesters. It owns the 3-bit select, steers the granted requester's
//   data to a single valid/ready output stream, and holds each grant for one
//   burst. A burst ends on the requester's last flag or after MAX_BURST beats.
//   It sits in front of the mux8_1 select network: sel drives the mux tree, and
//   the arbiter performs the same steering internally for the data bus.
// PARAMETERS
//   DATA_W     8   width of each requester data word
//   MAX_BURST  4   max beats per grant before forced release (1..255)
// PORTS
//   clk           in   1         rising-edge clock
//   rst           in   1         synchronous, active-high reset
//   req_valid     in   8         per-requester valid
//   req_data      in   8*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
//   req_last      in   8         per-requester end-of-burst flag
//   req_ready     out  8         one-hot ready back to the granted requester
//   out_valid     out  1         output stream valid
//   out_data      out  DATA_W    output stream data
//   out_last      out  1         final beat of the grant (req_last or cap hit)
//   out_ready     in   1         downstream ready
//   sel           out  3         registered select index for the 8:1 mux tree
//   busy          out  1         high while a grant is held
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE; ptr=0; sel=0; beat_cnt=0. busy=0,
//     out_valid=0, req_ready=0. out_data/out_last are don't-care while out_valid=0.
//     Reset mid-burst aborts immediately; no beat completes in that cycle.
//   States: IDLE, GRANT.
//   IDLE: busy=0, req_ready=0, out_valid=0.
//     - If any req_valid: winner = first i with req_valid[i], scanning ptr,
//       ptr+1, ... mod 8. Next cycle: sel=winner, beat_cnt=0, state=GRANT.
//     - Arbitration latency: 1 cycle from request seen to GRANT.
//   GRANT: busy=1. Datapath is combinational from sel:
//     - out_valid = req_valid[sel]; out_data = req_data[sel].
//     - req_ready = out_ready ? (8'b1 << sel) : 0.
//     - out_last = req_last[sel] | (beat_cnt == MAX_BURST-1).
//     - A beat completes when out_valid & out_ready; then beat_cnt++.
//     - On a beat with out_last=1: ptr=(sel+1) mod 8 (3-bit wrap), beat_cnt=0,
//       state=IDLE. This leaves a 1-cycle bubble between grants.
//     - If the granted requester drops req_valid mid-burst, the grant is held
//       with out_valid=0. There is no timeout and no preemption.
//     - Changes on req_valid of non-granted requesters have no effect until IDLE.
//   sel is stable for the whole GRANT; it changes only on the IDLE->GRANT edge.
//   Fairness: each requester that stays requesting is granted within 8 grants.
//   No combinational path from out_ready to out_valid.
// TESTING
//   1 Reset: rst=1 for 2 cycles with all req_valid=8'hFF ->
//     busy=0, out_valid=0, req_ready=0, sel=0.
//   2 Single requester: req_valid[5]=1, 2-beat burst with last on beat 2,
//     out_ready=1 -> sel=5 one cycle later; out_data equals req 5 data;
//     req_ready=8'h20; 2 beats; IDLE; ptr=6.
//   3 Round-robin: all 8 request continuously, req_last=1 every beat ->
//     sel sequence 0,1,...,7,0 with one idle cycle between grants.
//   4 Burst cap: req 2 holds last=0 for 10 beats, MAX_BURST=4 ->
//     out_last on beat 4; release; next grant starts scanning from 3.
//   5 Backpressure/gap: out_ready toggles 1,0,1 and req_valid[sel] drops for
//     2 cycles mid-burst -> beat_cnt counts only valid&ready; sel unchanged;
//     no data lost or duplicated.
//   6 Wrap and reset mid-burst: grant to 7 with last -> ptr=0, req 0 wins next.
//     Assert rst during a GRANT -> next cycle IDLE, sel=0, ptr=0.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 select path among 8 requesters.
// Holds each grant for one burst, ended by req_last or the beat cap.
module mux8_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        req_valid,
  input  logic [8*DATA_W-1:0] req_data,
  input  logic [7:0]        req_last,
  output logic [7:0]        req_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [2:0]        sel,
  output logic              busy
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [7:0] CAP = 8'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q;
  logic [2:0] sel_q;
  logic [7:0] beat_q;
  logic [2:0] win;
  logic       any_req;
  logic       fire;

  assign any_req = |req_valid;
  assign fire    = out_valid & out_ready;
  assign sel     = sel_q;

  // Descending scan so the lowest offset from ptr wins.
  always_comb begin
    logic [2:0] idx;
    idx = '0;
    win = ptr_q;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr_q + 3'(k);
      if (req_valid[idx]) win = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        sel_q  <= win;
        beat_q <= '0;
      end
      if (fire) begin
        if (out_last) begin
          ptr_q  <= sel_q + 3'd1;
          beat_q <= '0;
        end else begin
          beat_q <= beat_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (any_req) state_d = GRANT;
      GRANT: if (fire && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    req_ready = '0;
    unique case (state_q)
      IDLE: ;
      GRANT: begin
        busy      = 1'b1;
        out_valid = req_valid[sel_q];
        out_data  = req_data[sel_q*DATA_W +: DATA_W];
        out_last  = req_last[sel_q] | (beat_q == CAP);
        req_ready = out_ready ? (8'b1 << sel_q) : 8'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_mux8_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [7:0]  req_valid;
  logic [63:0] req_data;
  logic [7:0]  req_last;
  logic [7:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [2:0]  sel;
  logic        busy;

  logic [7:0]  dat [8];
  int          ncmp;
  int          nerr;

  mux8_rr_arbiter #(
    .DATA_W   (8),
    .MAX_BURST(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .sel      (sel),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < 8; i++) req_data[i*8 +: 8] = dat[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    ncmp      = 0;
    nerr      = 0;
    rst       = 1'b1;
    req_valid = 8'hFF;
    req_last  = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) dat[i] = 8'hA0 + 8'(i);

    // Reset held across two rising edges with everyone requesting
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_oval", 32'(out_valid), 0);
    chk("rst_rdy", 32'(req_ready), 0);
    chk("rst_sel", 32'(sel), 0);

    // Single requester 5, two-beat burst
    rst       = 1'b0;
    req_valid = 8'h20;
    dat[5]    = 8'h51;
    #1;
    chk("s_idle_busy", 32'(busy), 0);
    chk("s_idle_rdy", 32'(req_ready), 0);
    @(negedge clk); #1;
    chk("s_sel", 32'(sel), 5);
    chk("s_busy", 32'(busy), 1);
    chk("s_oval", 32'(out_valid), 1);
    chk("s_data1", 32'(out_data), 32'h51);
    chk("s_rdy", 32'(req_ready), 32'h20);
    chk("s_last1", 32'(out_last), 0);
    @(negedge clk);
    req_last = 8'h20;
    dat[5]   = 8'h52;
    #1;
    chk("s_data2", 32'(out_data), 32'h52);
    chk("s_last2", 32'(out_last), 1);
    chk("s_sel2", 32'(sel), 5);
    @(negedge clk);
    req_valid = 8'h41;
    req_last  = 8'hFF;
    #1;
    chk("s_back_idle", 32'(busy), 0);
    chk("s_idle_oval", 32'(out_valid), 0);
    @(negedge clk); #1;
    chk("s_ptr6", 32'(sel), 6);
    chk("s_rdy6", 32'(req_ready), 32'h40);

    // Round robin over all eight, one-beat bursts
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 8'hFF;
    #1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) dat[i] = 8'hA0 + 8'(i);
    #1;
    for (int k = 0; k < 9; k++) begin
      chk("rr_idle", 32'(busy), 0);
      @(negedge clk); #1;
      chk("rr_sel", 32'(sel), 32'(k % 8));
      chk("rr_data", 32'(out_data), 32'(8'hA0 + 8'(k % 8)));
      chk("rr_last", 32'(out_last), 1);
      @(negedge clk); #1;
    end

    // Burst cap: requester 2 never raises last
    req_valid = 8'h04;
    req_last  = 8'h00;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      dat[2] = 8'h20 + 8'(b);
      #1;
      chk("cap_sel", 32'(sel), 2);
      chk("cap_data", 32'(out_data), 32'(8'h20 + 8'(b)));
      chk("cap_last", 32'(out_last), (b == 3) ? 1 : 0);
    end
    @(negedge clk);
    req_valid = 8'h0D;
    #1;
    chk("cap_idle", 32'(busy), 0);

    // Backpressure and valid gap on requester 3
    @(negedge clk);
    dat[3] = 8'h31;
    #1;
    chk("bp_sel", 32'(sel), 3);
    chk("bp_a_rdy", 32'(req_ready), 32'h08);
    chk("bp_a_data", 32'(out_data), 32'h31);
    chk("bp_a_last", 32'(out_last), 0);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("bp_b_oval", 32'(out_valid), 1);
    chk("bp_b_rdy", 32'(req_ready), 0);
    @(negedge clk);
    out_ready = 1'b1;
    req_valid = 8'h05;
    #1;
    chk("bp_c_oval", 32'(out_valid), 0);
    chk("bp_c_busy", 32'(busy), 1);
    chk("bp_c_sel", 32'(sel), 3);
    @(negedge clk); #1;
    chk("bp_d_oval", 32'(out_valid), 0);
    chk("bp_d_sel", 32'(sel), 3);
    @(negedge clk);
    req_valid = 8'h0D;
    dat[3]    = 8'h32;
    #1;
    chk("bp_e_data", 32'(out_data), 32'h32);
    chk("bp_e_last", 32'(out_last), 0);
    @(negedge clk);
    dat[3] = 8'h33;
    #1;
    chk("bp_f_data", 32'(out_data), 32'h33);
    chk("bp_f_last", 32'(out_last), 0);
    @(negedge clk);
    dat[3] = 8'h34;
    #1;
    chk("bp_g_data", 32'(out_data), 32'h34);
    chk("bp_g_last", 32'(out_last), 1);

    // Pointer wrap past 7, then reset in the middle of a burst
    @(negedge clk);
    req_valid = 8'h81;
    req_last  = 8'hFF;
    #1;
    chk("w_idle", 32'(busy), 0);
    @(negedge clk); #1;
    chk("w_sel7", 32'(sel), 7);
    @(negedge clk); #1;
    chk("w_idle2", 32'(busy), 0);
    @(negedge clk); #1;
    chk("w_sel0", 32'(sel), 0);
    @(negedge clk);
    req_valid = 8'h80;
    req_last  = 8'h00;
    #1;
    @(negedge clk); #1;
    chk("mr_sel7", 32'(sel), 7);
    chk("mr_busy", 32'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 8'h81;
    #1;
    chk("mr_busy0", 32'(busy), 0);
    chk("mr_sel0", 32'(sel), 0);
    chk("mr_oval", 32'(out_valid), 0);
    chk("mr_rdy", 32'(req_ready), 0);
    @(negedge clk); #1;
    chk("mr_ptr0", 32'(sel), 0);
    chk("mr_busy1", 32'(busy), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
